clk_div_multi: RTL and testbench

Parametrised multi-channel clock divider producing a 50 % duty-cycle slow clock and a one-cycle tick per channel from the single system clock. It is the general replacement for the fixed single-rate dividers in the clocking layer. Each channel has a runtime-programmable half-period and its own enable. Divisor changes are glitch-free. An optional global sync realigns all channels.

---
 rtl/clk_div_multi.sv | 73 +++++++
 tb/tb_clk_div_multi.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// Multi-channel 50 % duty clock divider with a per-channel toggle tick and glitch-free divisor reload.
// Define CLKDIV_SYNC_EN to compile in the global phase-realign path driven by sync_i.
module clk_div_multi #(
    parameter int unsigned      NUM_CH  = 3,
    parameter int unsigned      CNT_W   = 32,
    parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(4_999_999)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       en_i,
    input  logic [NUM_CH*CNT_W-1:0] div_i,
    input  logic                    sync_i,
    output logic [NUM_CH-1:0]       clk_ls,
    output logic [NUM_CH-1:0]       tick_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifndef CLKDIV_SYNC_EN
    logic sync_unused;
    assign sync_unused = sync_i;
`endif

    genvar n;
    generate
        for (n = 0; n < NUM_CH; n++) begin : g_ch
            logic [CNT_W-1:0] cnt;
            logic [CNT_W-1:0] act_div;
            logic [CNT_W-1:0] div_n;
            logic             clk_q;
            logic             tick_q;
            logic             wrap;

            assign div_n = div_i[n*CNT_W +: CNT_W];
            // Exact equality keeps cnt <= act_div, so the all-ones divisor never overflows.
            assign wrap  = (cnt == act_div);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt     <= '0;
                    act_div <= DEF_DIV;
                    clk_q   <= 1'b0;
                    tick_q  <= 1'b0;
                end else if (!en_i[n]) begin
                    cnt     <= '0;
                    act_div <= div_n;
                    clk_q   <= 1'b0;
                    tick_q  <= 1'b0;
`ifdef CLKDIV_SYNC_EN
                end else if (sync_i) begin
                    cnt     <= '0;
                    act_div <= div_n;
                    clk_q   <= 1'b0;
                    tick_q  <= 1'b0;
`endif
                end else if (wrap) begin
                    // New divisor only takes effect at a half-period boundary.
                    cnt     <= '0;
                    act_div <= div_n;
                    clk_q   <= ~clk_q;
                    tick_q  <= 1'b1;
                end else begin
                    cnt     <= cnt + CNT_ONE;
                    tick_q  <= 1'b0;
                end
            end

            assign clk_ls[n] = clk_q;
            assign tick_o[n] = tick_q;
        end
    endgenerate

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: event-scheduled reference model plus directed literal checks.
// Honours CLKDIV_SYNC_EN in the model and in the sync scenario.
module tb_clk_div_multi;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 8;
    localparam int DEF    = 9;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NUM_CH-1:0]       en_i;
    logic [NUM_CH*CNT_W-1:0] div_i;
    logic                    sync_i;
    logic [NUM_CH-1:0]       clk_ls;
    logic [NUM_CH-1:0]       tick_o;

    int total = 0;
    int bad   = 0;

    clk_div_multi #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .DEF_DIV(CNT_W'(DEF))
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (en_i),
        .div_i (div_i),
        .sync_i(sync_i),
        .clk_ls(clk_ls),
        .tick_o(tick_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each running channel keeps the absolute edge index of its next toggle.
    bit     m_lvl  [NUM_CH];
    bit     m_tick [NUM_CH];
    bit     m_run  [NUM_CH];
    longint m_next [NUM_CH];
    longint m_pend [NUM_CH];
    longint k;

    always @(posedge clk or negedge rst_n) begin
        longint d;
        if (!rst_n) begin
            for (int n = 0; n < NUM_CH; n++) begin
                m_lvl[n]  = 1'b0;
                m_tick[n] = 1'b0;
                m_run[n]  = 1'b0;
                m_pend[n] = DEF;
                m_next[n] = 0;
            end
            k = 0;
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                d = longint'(div_i[n*CNT_W +: CNT_W]);
                if (!en_i[n]) begin
                    m_lvl[n]  = 1'b0;
                    m_tick[n] = 1'b0;
                    m_run[n]  = 1'b0;
                    m_pend[n] = d;
`ifdef CLKDIV_SYNC_EN
                end else if (sync_i) begin
                    m_lvl[n]  = 1'b0;
                    m_tick[n] = 1'b0;
                    m_run[n]  = 1'b1;
                    m_next[n] = k + 1 + d;
`endif
                end else begin
                    if (!m_run[n]) begin
                        m_run[n]  = 1'b1;
                        m_next[n] = k + m_pend[n];
                    end
                    if (k == m_next[n]) begin
                        m_lvl[n]  = ~m_lvl[n];
                        m_tick[n] = 1'b1;
                        m_next[n] = k + 1 + d;
                    end else begin
                        m_tick[n] = 1'b0;
                    end
                end
            end
            k++;
        end
    end

    always @(negedge clk) begin
        logic [NUM_CH-1:0] el;
        logic [NUM_CH-1:0] et;
        for (int n = 0; n < NUM_CH; n++) begin
            el[n] = m_lvl[n];
            et[n] = m_tick[n];
        end
        check("model_clk_ls", 64'(clk_ls), 64'(el));
        check("model_tick_o", 64'(tick_o), 64'(et));
    end

    task automatic set_div(input int ch, input int v);
        div_i[ch*CNT_W +: CNT_W] = CNT_W'(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic edges_until_rise(input int ch, input int maxe, output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!clk_ls[ch] && cnt < maxe);
    endtask

    task automatic edges_until_tick(input int ch, input int maxe, output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!tick_o[ch] && cnt < maxe);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, t0, t1, t2, o0, o1, o2, r1, r2, lim;
        rst_n  = 1'b0;
        en_i   = 3'b001;
        div_i  = '0;
        sync_i = 1'b0;
        for (int n = 0; n < NUM_CH; n++) set_div(n, 3);

        repeat (3) begin
            @(negedge clk);
            check("rst_clk_ls", 64'(clk_ls), 64'd0);
            check("rst_tick_o", 64'(tick_o), 64'd0);
        end
        step();
        rst_n = 1'b1;
        edges_until_rise(0, 50, c);
        check("def_div_first_rise", c, 10);

        // Basic divide with D = {0,4,9}
        en_i = '0;
        set_div(0, 0); set_div(1, 4); set_div(2, 9);
        step();
        en_i = 3'b111;
        step(); step();
        {t0, t1, t2, o0, o1, o2} = '0;
        for (int i = 0; i < 100; i++) begin
            step();
            t0 += int'(tick_o[0]); t1 += int'(tick_o[1]); t2 += int'(tick_o[2]);
            o0 += int'(clk_ls[0]); o1 += int'(clk_ls[1]); o2 += int'(clk_ls[2]);
        end
        check("basic_ticks_ch0", t0, 100);
        check("basic_ticks_ch1", t1, 20);
        check("basic_ticks_ch2", t2, 10);
        check("basic_high_ch0", o0, 50);
        check("basic_high_ch1", o1, 50);
        check("basic_high_ch2", o2, 50);

        // Glitch-free reload on ch1 at cnt=2
        lim = 0;
        do begin step(); lim++; end while (!tick_o[1] && lim < 20);
        check("reload_wait_tick", 64'(tick_o[1]), 64'd1);
        step(); step();
        set_div(1, 1);
        edges_until_tick(1, 20, c);
        check("reload_gap_current", c + 2, 5);
        edges_until_tick(1, 20, c);
        check("reload_gap_next1", c, 2);
        edges_until_tick(1, 20, c);
        check("reload_gap_next2", c, 2);

        // Enable toggling on ch2 while its clock is high
        lim = 0;
        do begin step(); lim++; end while (!(tick_o[2] && clk_ls[2]) && lim < 100);
        check("en_wait_high", 64'(clk_ls[2]), 64'd1);
        step(); step(); step();
        en_i[2] = 1'b0;
        set_div(2, 3);
        step();
        check("dis_clk_ls2", 64'(clk_ls[2]), 64'd0);
        check("dis_tick2", 64'(tick_o[2]), 64'd0);
        en_i[2] = 1'b1;
        edges_until_rise(2, 50, c);
        check("reen_first_rise", c, 4);

        // Async reset between edges while ch1 is high
        lim = 0;
        do begin step(); lim++; end while (!clk_ls[1] && lim < 20);
        check("ares_wait_high", 64'(clk_ls[1]), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ares_clk_ls", 64'(clk_ls), 64'd0);
        check("ares_tick_o", 64'(tick_o), 64'd0);
        step();
        rst_n = 1'b1;
        edges_until_rise(1, 50, c);
        check("ares_def_div_rise", c, 10);

        // Largest legal divisor
        en_i[2] = 1'b0;
        set_div(2, 255);
        step();
        en_i[2] = 1'b1;
        edges_until_rise(2, 600, c);
        check("maxdiv_first_rise", c, 256);
        edges_until_tick(2, 600, c);
        check("maxdiv_half_period", c, 256);

        // Sync pulse on a ch1 wrap edge
        en_i = 3'b001;
        set_div(1, 4); set_div(2, 9);
        step();
        en_i = 3'b111;
        lim = 0;
        do begin step(); lim++; end while (!tick_o[1] && lim < 20);
        check("sync_wait_tick", 64'(tick_o[1]), 64'd1);
        repeat (4) step();
        sync_i = 1'b1;
        step();
        sync_i = 1'b0;
`ifdef CLKDIV_SYNC_EN
        check("sync_no_tick1", 64'(tick_o[1]), 64'd0);
        check("sync_clk_ls1", 64'(clk_ls[1]), 64'd0);
        check("sync_clk_ls2", 64'(clk_ls[2]), 64'd0);
        r1 = 0; r2 = 0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (r1 == 0 && clk_ls[1]) r1 = i;
            if (r2 == 0 && clk_ls[2]) r2 = i;
        end
        check("sync_rise_ch1", r1, 5);
        check("sync_rise_ch2", r2, 10);
`else
        check("nosync_tick1", 64'(tick_o[1]), 64'd1);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step();
            if ($urandom_range(0, 19) == 0) en_i[$urandom_range(0, NUM_CH-1)] ^= 1'b1;
            if ($urandom_range(0, 9) == 0) set_div($urandom_range(0, NUM_CH-1), $urandom_range(0, 12));
            if ($urandom_range(0, 299) == 0) set_div($urandom_range(0, NUM_CH-1), 255);
            sync_i = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #1;
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end
        end
        sync_i = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
